// File: rtl/exe_muldiv_unit_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit.
// Operation codes and FSM state encodings.
package exe_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MULDIV_OP_MULT  = 2'b00,
    MULDIV_OP_MULTU = 2'b01,
    MULDIV_OP_DIV   = 2'b10,
    MULDIV_OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_st_e;

endpackage

// File: rtl/exe_muldiv_unit_div_radix2_core.sv
// Iterative radix-2 restoring divider on unsigned operands.
// rem_o/quo_o are the values after the current step.
module div_radix2_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   diff;

  // quo_q shifts dividend bits out the top and quotient bits in the bottom
  always_comb begin
    diff = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dvd_i;
      dvs_q <= dvs_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign rem_o = rem_d;
  assign quo_o = quo_d;

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multi-cycle multiply/divide unit returning {hi,lo}.
// Holds the pipeline via stall until the one-cycle done pulse.
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int W2 = 2 * WIDTH;

  muldiv_st_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             dsgn_q;
  logic [W2-1:0]    result_q, result_d;

  logic             accept;
  logic             msgn;
  logic [W2-1:0]    a_x, b_x, prod, mul_tail;
  logic             core_load, core_step;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_n, quo_n, rem_f, quo_f;
  logic             neg_q, neg_r;
  logic [W2-1:0]    div_res;

  assign accept = start & ~flush & (state_q == ST_IDLE);

  assign msgn = (op == MULDIV_OP_MULT);
  assign a_x  = {{WIDTH{msgn & srca[WIDTH-1]}}, srca};
  assign b_x  = {{WIDTH{msgn & srcb[WIDTH-1]}}, srcb};
  assign prod = a_x * b_x;

  // Product is captured at accept; the last stage is result_q itself
  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic [W2-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
        end else begin
          if (accept) pipe_q[0] <= prod;
          for (int i = 1; i < MUL_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_tail = pipe_q[MUL_LAT-2];
    end else begin : g_nopipe
      assign mul_tail = prod;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opa_q  <= '0;
      opb_q  <= '0;
      dsgn_q <= 1'b0;
    end else if (accept) begin
      opa_q  <= srca;
      opb_q  <= srcb;
      dsgn_q <= (op == MULDIV_OP_DIV);
    end
  end

  assign core_load = (state_q == ST_DIV) && (cnt_q == '0);
  assign core_step = (state_q == ST_DIV) && (cnt_q != '0);

  assign abs_a = (dsgn_q & opa_q[WIDTH-1]) ? -opa_q : opa_q;
  assign abs_b = (dsgn_q & opb_q[WIDTH-1]) ? -opb_q : opb_q;

  div_radix2_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk   (clk),
    .resetn(resetn),
    .load_i(core_load),
    .step_i(core_step),
    .dvd_i (abs_a),
    .dvs_i (abs_b),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign neg_q   = dsgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
  assign neg_r   = dsgn_q & opa_q[WIDTH-1];
  assign quo_f   = neg_q ? -quo_n : quo_n;
  assign rem_f   = neg_r ? -rem_n : rem_n;
  // Zero divisor: all-ones quotient, dividend passed through as remainder
  assign div_res = (opb_q == '0) ? {opa_q, {WIDTH{1'b1}}}
                                 : {rem_f, quo_f};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (op[1]) begin
            state_d = ST_DIV;
          end else if (MUL_LAT == 1) begin
            state_d  = ST_DONE;
            result_d = mul_tail;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CW'(MUL_LAT - 2)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = mul_tail;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = div_res;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  assign stall  = (start & (state_q == ST_IDLE))
                | (state_q == ST_MUL)
                | (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Bench for exe_muldiv_unit: vector table, scoreboard queue,
// and hand sequences for flush, reset and busy-start cases.
module tb_exe_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  srca, srcb;
  logic          stall, done;
  logic [2*W-1:0] result;

  exe_muldiv_unit #(
    .WIDTH  (W),
    .MUL_LAT(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .flush (flush),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%016h, none expected",
                 result);
      end else begin
        chk("sb_result", result, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res,
                        input int lat, input int id);
    int   n;
    logic bad_stall;
    @(posedge clk); #1;
    start = 1'b1; op = o; srca = a; srcb = b;
    exp_q.push_back(res);
    @(negedge clk);
    chk($sformatf("stall_issue[%0d]", id), 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
    op    = 2'($urandom_range(0, 3));
    n = 1;
    bad_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (stall !== 1'b1) bad_stall = 1'b1;
      n++;
      if (n > 100) break;
    end
    chk($sformatf("latency[%0d]", id), 64'(n), 64'(lat));
    chk($sformatf("stall_busy[%0d]", id), 64'(bad_stall), 64'd0);
    chk($sformatf("stall_done[%0d]", id), 64'(stall), 64'd0);
    @(negedge clk);
    chk($sformatf("done_pulse[%0d]", id), 64'(done), 64'd0);
    chk($sformatf("result_hold[%0d]", id), result, res);
    last_res = res;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn, dc;
    resetn = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; srca = '0; srcb = '0;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 2};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, 34};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
    vecs[5]  = '{2'b11, 32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF, 34};
    vecs[6]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 34};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 2};
    vecs[8]  = '{2'b01, 32'd3,        32'd4,        64'h00000000_0000000C, 2};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 34};
    vecs[11] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 34};
    vecs[12] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 2};
    vecs[13] = '{2'b11, 32'd5,        32'd7,        64'h00000005_00000000, 34};
    vecs[14] = '{2'b01, 32'h80000000, 32'd2,        64'h00000001_00000000, 2};

    repeat (2) @(negedge clk);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i);

    // DIV aborted by flush at cycle 10, then MULTU at cycle 12
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_c10", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall_c11", 64'(stall), 64'd0);
    chk("flush_done_c11", 64'(done), 64'd0);
    chk("flush_result_c11", result, last_res);
    run_op(2'b01, 32'd3, 32'd4, 64'hC, 2, 100);

    // flush and start together: start dropped
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b11; srca = 32'd50; srcb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("fs_idle[%0d]", k), {62'd0, stall, done}, 64'd0);
    end
    chk("fs_result", result, last_res);

    // extra start during DIVU is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; srca = 32'd100; srcb = 32'd7;
    exp_q.push_back(64'h00000002_0000000E);
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; dc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 2'b01; srca = 32'd9; srcb = 32'd3;
      end
      if (c == 6) start = 1'b0;
      @(negedge clk);
      if (done) begin
        dn++;
        dc = c;
      end
      @(posedge clk); #1;
    end
    chk("busy_start_done_count", 64'(dn), 64'd1);
    chk("busy_start_done_cycle", 64'(dc), 64'd34);
    chk("busy_start_result", result, 64'h00000002_0000000E);

    // async reset in the middle of a DIV
    start = 1'b1; op = 2'b10; srca = 32'hFFFFFF00; srcb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_res = '0;
    run_op(2'b00, 32'hFFFFFFFE, 32'd7, 64'hFFFFFFFF_FFFFFFF2, 2, 200);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
